neuron_result_collector: RTL and testbench

- Consumes the stream of 40-bit accumulator results produced by a layer's neurons, one result per neuron-done pulse.
- Requantizes each result to 16-bit with optional ReLU, arithmetic shift and saturation, and stores it in an activation buffer.
- Tracks the argmax across the layer.
- Once all NUM_NEURONS results have arrived, exposes the buffer through a 1-cycle-latency read port, which feeds the next layer's din_x or the final class decision.

---
 rtl/mnist_pkg.sv | 20 ++
 rtl/requant_sat.sv | 32 +++
 rtl/neuron_result_collector.sv | 125 ++++++++++++
 tb/tb_neuron_result_collector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST inference datapath.
// Holds the data/accumulator widths, the result-collector state encoding and
// the 16-bit saturation bounds used when requantizing accumulator results.
package mnist_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2
  } collector_state_t;

  // Saturation bounds expressed at accumulator width so comparisons against
  // the shifted accumulator stay signed and width-matched.
  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: 40-bit signed accumulator -> 16-bit signed value.
// Optional ReLU (negative inputs become 0), then floor arithmetic right shift
// by SHIFT, then saturation to the signed 16-bit range.
// Ports:
//   acc  in  ACC_W signed   accumulator result
//   q    out DATA_W signed  requantized value
module requant_sat
  import mnist_pkg::*;
#(
  parameter int SHIFT   = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] q
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> SHIFT;
    if (RELU_EN && (acc < 0)) begin
      q = '0;
    end else if (shifted > SAT_MAX) begin
      q = DATA_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      q = DATA_W'(SAT_MIN);
    end else begin
      q = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_result_collector.sv
// Collects one layer's worth of neuron accumulator results, requantizes each
// to 16 bits, stores them in an activation buffer, tracks the argmax, and then
// exposes the buffer through a registered read port.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start                pulse: begin (or restart) collecting a layer
//   acc_valid, acc_data  one accumulator result per pulse
//   rd_en, rd_addr       read request into the buffer (accepted in READY)
//   rd_data, rd_valid    read result, one cycle after an accepted read
//   busy, ready          registered decodes of COLLECT / READY
//   layer_done           pulse on entry to READY
//   max_idx, max_val     argmax over the layer (ties keep the lower index)
//   overflow_err         sticky: a result arrived outside COLLECT
module neuron_result_collector
  import mnist_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int SHIFT       = 8,
  parameter bit RELU_EN     = 1'b1,
  localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     acc_valid,
  input  logic signed [ACC_W-1:0]  acc_data,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     ready,
  output logic                     layer_done,
  output logic [IDX_W-1:0]         max_idx,
  output logic signed [DATA_W-1:0] max_val,
  output logic                     overflow_err
);

  collector_state_t         state, state_next;
  logic [IDX_W-1:0]         count;
  logic signed [DATA_W-1:0] q;
  logic signed [DATA_W-1:0] buffer [NUM_NEURONS];
  logic                     accept;
  logic                     last;
  logic                     rd_accept;
  logic                     rd_in_range;

  requant_sat #(
    .SHIFT   (SHIFT),
    .RELU_EN (RELU_EN)
  ) u_requant (
    .acc (acc_data),
    .q   (q)
  );

  // start has priority over a coincident result, which is dropped silently.
  assign accept      = acc_valid && !start && (state == ST_COLLECT);
  assign last        = accept && (count == IDX_W'(NUM_NEURONS - 1));
  assign rd_accept   = rd_en && (state == ST_READY);
  assign rd_in_range = {1'b0, rd_addr} < (IDX_W + 1)'(NUM_NEURONS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_COLLECT;
    end else if (last) begin
      state_next = ST_READY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      max_idx      <= '0;
      max_val      <= '0;
      overflow_err <= 1'b0;
      busy         <= 1'b0;
      ready        <= 1'b0;
      layer_done   <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      busy       <= (state_next == ST_COLLECT);
      ready      <= (state_next == ST_READY);
      layer_done <= last;

      if (start) begin
        count        <= '0;
        max_idx      <= '0;
        max_val      <= '0;
        overflow_err <= 1'b0;
      end else if (accept) begin
        count <= count + 1'b1;
        // First sample always seeds the argmax; strict compare keeps ties low.
        if ((count == '0) || (q > max_val)) begin
          max_val <= q;
          max_idx <= count;
        end
      end else if (acc_valid) begin
        overflow_err <= 1'b1;
      end

      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= rd_in_range ? buffer[rd_addr] : '0;
      end
    end
  end

  // Buffer contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[count] <= q;
    end
  end

endmodule

// File: tb/tb_neuron_result_collector.sv
module tb_neuron_result_collector;
  import mnist_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     acc_valid = 1'b0;
  logic signed [ACC_W-1:0]  acc_data = '0;
  logic                     rd_en = 1'b0;
  logic [3:0]               rd_addr = '0;

  // Outputs of the ReLU-enabled instance (a) and the ReLU-disabled one (b).
  logic signed [DATA_W-1:0] rd_data_a, rd_data_b, max_val_a, max_val_b;
  logic                     rd_valid_a, rd_valid_b, busy_a, busy_b, ready_a, ready_b;
  logic                     layer_done_a, layer_done_b, ovf_a, ovf_b;
  logic [3:0]               max_idx_a, max_idx_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  neuron_result_collector #(.NUM_NEURONS(10), .SHIFT(8), .RELU_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .acc_valid(acc_valid), .acc_data(acc_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .busy(busy_a), .ready(ready_a), .layer_done(layer_done_a), .max_idx(max_idx_a),
    .max_val(max_val_a), .overflow_err(ovf_a)
  );

  neuron_result_collector #(.NUM_NEURONS(10), .SHIFT(8), .RELU_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .acc_valid(acc_valid), .acc_data(acc_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .busy(busy_b), .ready(ready_b), .layer_done(layer_done_b), .max_idx(max_idx_b),
    .max_val(max_val_b), .overflow_err(ovf_b)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic signed [ACC_W-1:0] v);
    acc_valid = 1'b1;
    acc_data  = v;
    tick();
    acc_valid = 1'b0;
  endtask

  // Issue a read; leaves rd_en high so consecutive calls are back-to-back.
  task automatic rd(input logic [3:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
  endtask

  logic signed [31:0] exp_a [10];
  logic signed [31:0] exp_b [10];

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_rd_data", rd_data_a, 0);
    check("rst_rd_valid", rd_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_layer_done", layer_done_a, 0);
    check("rst_max_idx", max_idx_a, 0);
    check("rst_max_val", max_val_a, 0);
    check("rst_overflow", ovf_a, 0);
    rst = 1'b0;
    tick();

    // ---------------- ramp layer: acc = 256*k ----------------
    pulse_start();
    check("ramp_busy", busy_a, 1);
    for (int k = 0; k < 10; k++) begin
      feed(40'(256 * k));
      check($sformatf("ramp_layer_done_%0d", k), layer_done_a, (k == 9) ? 1 : 0);
    end
    check("ramp_ready", ready_a, 1);
    check("ramp_busy_low", busy_a, 0);
    check("ramp_max_idx", max_idx_a, 9);
    check("ramp_max_val", max_val_a, 9);
    tick();
    check("ramp_layer_done_once", layer_done_a, 0);
    for (int k = 0; k < 10; k++) begin
      rd(4'(k));
      check($sformatf("ramp_rd_%0d", k), rd_data_a, k);
      check($sformatf("ramp_rd_valid_%0d", k), rd_valid_a, 1);
    end
    rd_en = 1'b0;
    tick();
    check("rd_valid_drop", rd_valid_a, 0);

    // ---------------- acc_valid while READY ----------------
    feed(40'sd1073741824);
    check("ready_ovf", ovf_a, 1);
    rd(4'd9);
    check("ready_buf_unchanged", rd_data_a, 9);
    rd_en = 1'b0;

    // ---------------- saturation / ReLU / floor ----------------
    pulse_start();
    check("sat_ovf_cleared", ovf_a, 0);
    feed(40'sd1073741824);
    feed(-40'sd2560);
    feed(-40'sd1073741824);
    feed(-40'sd1);
    feed(40'sd127);
    for (int k = 5; k < 10; k++) feed(40'sd0);
    exp_a = '{32767, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_b = '{32767, -10, -32768, -1, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      rd(4'(k));
      check($sformatf("relu_rd_%0d", k), rd_data_a, exp_a[k]);
      check($sformatf("norelu_rd_%0d", k), rd_data_b, exp_b[k]);
    end
    rd_en = 1'b0;
    check("sat_max_idx", max_idx_a, 0);
    check("sat_max_val", max_val_a, 32767);

    // ---------------- ties ----------------
    pulse_start();
    feed(40'(256 * 10));
    feed(40'(256 * 50));
    feed(40'(256 * 50));
    feed(40'(256 * 3));
    for (int k = 4; k < 10; k++) feed(40'sd0);
    check("tie_max_idx", max_idx_a, 1);
    check("tie_max_val", max_val_a, 50);

    // ---------------- start + acc_valid, read in COLLECT ----------------
    feed(40'sd256);
    check("tie_ready_ovf", ovf_a, 1);
    start = 1'b1;
    acc_valid = 1'b1;
    acc_data = 40'(256 * 1000);
    tick();
    start = 1'b0;
    acc_valid = 1'b0;
    check("startacc_ovf", ovf_a, 0);
    check("startacc_busy", busy_a, 1);
    check("startacc_max_val", max_val_a, 0);
    rd(4'd0);
    check("collect_rd_valid", rd_valid_a, 0);
    rd_en = 1'b0;
    for (int k = 0; k < 10; k++) feed(40'(256 * (k + 20)));
    check("startacc_ready", ready_a, 1);
    check("startacc_max_idx", max_idx_a, 9);
    check("startacc_max_val_final", max_val_a, 29);
    rd(4'd0);
    check("startacc_rd0", rd_data_a, 20);
    rd_en = 1'b0;

    // ---------------- async reset mid-collection ----------------
    pulse_start();
    for (int k = 0; k < 4; k++) feed(40'(256 * (k + 5)));
    check("pre_rst_max_val", max_val_a, 8);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_max_val", max_val_a, 0);
    check("arst_max_idx", max_idx_a, 0);
    check("arst_rd_data", rd_data_a, 0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_idle_busy", busy_a, 0);
    pulse_start();
    for (int k = 0; k < 10; k++) feed(40'(256 * (9 - k)));
    check("arst_layer_done", layer_done_a, 1);
    check("arst_relayer_max_idx", max_idx_a, 0);
    check("arst_relayer_max_val", max_val_a, 9);
    rd(4'd3);
    check("arst_relayer_rd3", rd_data_a, 6);

    // ---------------- out-of-range read ----------------
    rd(4'd12);
    check("oor_rd_data", rd_data_a, 0);
    check("oor_rd_valid", rd_valid_a, 1);
    rd_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
